// File: rtl/fwd_pkg.sv
// Shared types and defaults for the ID/EX forwarding and hazard unit.
// `define FWD_ZERO_REG_EN to make register 0 a hardwired zero.
package fwd_pkg;

    localparam int DEF_REG_AW  = 4;
    localparam int DEF_NUM_SRC = 3;
    localparam int DEF_MC_LAT  = 4;

`ifdef FWD_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        FW_RF      = 2'b00,
        FW_MEM_LD  = 2'b01,
        FW_MEM_ALU = 2'b10,
        FW_WB      = 2'b11
    } fw_sel_t;

    // The EX producer is one stage nearer than MEM, so it always wins.
    function automatic fw_sel_t fwd_pick(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit);
        fw_sel_t s;
        if (ex_hit)       s = ex_ld ? FW_MEM_LD : FW_MEM_ALU;
        else if (mem_hit) s = FW_WB;
        else              s = FW_RF;
        return s;
    endfunction

endpackage

// File: rtl/fwd_scoreboard.sv
// Per-register countdown of in-flight multi-cycle results.
// With FWD_ZERO_REG_EN defined an issue to r0 leaves the table untouched.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int MC_LAT   = DEF_MC_LAT,
    parameter int NUM_REGS = 2**REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_i,
    input  logic [REG_AW-1:0]   issue_rd_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                sb_busy_o
);

    localparam int CW = $clog2(MC_LAT + 1);
    localparam logic [CW-1:0] LAT_C = CW'(MC_LAT);

    logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;
    logic                        load_ok;

    assign load_ok = issue_i && !(ZERO_REG_EN && (issue_rd_i == '0));

    // A fresh issue reloads; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (load_ok && (issue_rd_i == REG_AW'(r)))
                cnt_d[r] = LAT_C;
            else if (cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++)
            pending_o[r] = (cnt_q[r] != '0);
    end

    assign sb_busy_o = |pending_o;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding selects, RAW/WAW stall against the MC scoreboard,
// and the ID/EX select/bubble register. Honours `FWD_ZERO_REG_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = DEF_REG_AW,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int MC_LAT  = DEF_MC_LAT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_mc,
    input  logic                      flush,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      ex_regwrite,
    input  logic                      mem_regwrite,
    input  logic                      ex_memtoreg,
    output logic                      stall,
    output logic [2*NUM_SRC-1:0]      fw_sel_q,
    output logic                      ex_bubble_q,
    output logic                      sb_busy
);

    localparam int NUM_REGS = 2**REG_AW;

    logic [NUM_REGS-1:0]  pending;
    logic [2*NUM_SRC-1:0] fw_sel_d;
    logic                 ex_bubble_d;
    logic                 raw_hit, waw_hit, issue;

    // MC results are never forwarded; a pending source simply stalls.
    always_comb begin
        fw_sel_d = '0;
        raw_hit  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_AW-1:0] rs;
            logic              live;
            rs   = id_rs[i*REG_AW +: REG_AW];
            live = id_rs_used[i] && !(ZERO_REG_EN && (rs == '0));
            if (live) begin
                fw_sel_d[2*i +: 2] = fwd_pick(ex_regwrite  && (rs == ex_rd),
                                              ex_memtoreg,
                                              mem_regwrite && (rs == mem_rd));
                raw_hit = raw_hit | pending[rs];
            end
        end
    end

    assign waw_hit = (id_regwrite | id_is_mc) && pending[id_rd];
    assign stall   = id_valid && !flush && (raw_hit || waw_hit);
    assign issue   = id_valid && id_is_mc && !stall && !flush;

    fwd_scoreboard #(
        .REG_AW (REG_AW),
        .MC_LAT (MC_LAT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (issue),
        .issue_rd_i (id_rd),
        .pending_o  (pending),
        .sb_busy_o  (sb_busy)
    );

    assign ex_bubble_d = stall || flush || !id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fw_sel_q    <= '0;
            ex_bubble_q <= 1'b1;
        end else if (ex_bubble_d) begin
            fw_sel_q    <= '0;
            ex_bubble_q <= 1'b1;
        end else begin
            fw_sel_q    <= fw_sel_d;
            ex_bubble_q <= 1'b0;
        end
    end

endmodule
